// File: rtl/operand_fetch_if.sv
// Operand-fetch bus bundle: decoder issue side, writeback port and ALU-facing output handshake.
//   slave  : operand_fetch view (issue/writeback/out_ready in; issue_ready/out_valid/ain/bin/aluop out)
//   master : decoder + writeback + ALU view (the mirror image)
interface operand_fetch_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned IDX_W  = 3
);
    logic              issue_valid;
    logic              issue_ready;
    logic [IDX_W-1:0]  rn;
    logic [IDX_W-1:0]  rm;
    logic [1:0]        shift;
    logic              asel;
    logic              bsel;
    logic [DATA_W-1:0] sximm5;
    logic [1:0]        aluop_in;
    logic              wb_en;
    logic [IDX_W-1:0]  wb_num;
    logic [DATA_W-1:0] wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] ain;
    logic [DATA_W-1:0] bin;
    logic [1:0]        aluop;

    modport slave (
        input  issue_valid, rn, rm, shift, asel, bsel, sximm5, aluop_in,
        input  wb_en, wb_num, wb_data, out_ready,
        output issue_ready, out_valid, ain, bin, aluop
    );

    modport master (
        output issue_valid, rn, rm, shift, asel, bsel, sximm5, aluop_in,
        output wb_en, wb_num, wb_data, out_ready,
        input  issue_ready, out_valid, ain, bin, aluop
    );
endinterface

// File: rtl/operand_fetch.sv
// Operand-fetch stage feeding the 16-bit ALU.
// 8-entry register file with one read port, reads A then B over two cycles, applies a 1-bit
// shift to B, selects A/B sources and presents ain/bin/aluop with a valid/ready handshake.
// Ports:
//   clk   : clock, rising-edge
//   rst_n : synchronous active-low reset
//   bus   : operand_fetch_if.slave (issue, writeback and output handshake signals)
// Optional feature: define OPF_BYPASS_EN to forward a same-cycle writeback into the operand
// being read in RD_A/RD_B; otherwise the read returns the pre-write register contents.
module operand_fetch #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREGS  = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    operand_fetch_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NREGS);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD_A = 2'd1;
    localparam logic [1:0] RD_B = 2'd2;
    localparam logic [1:0] OUT  = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic              accept;
    logic              load_a;
    logic              load_b;

    logic [DATA_W-1:0] regs [NREGS];

    logic [IDX_W-1:0]  rn_q;
    logic [IDX_W-1:0]  rm_q;
    logic [1:0]        shift_q;
    logic              asel_q;
    logic              bsel_q;
    logic [DATA_W-1:0] imm_q;
    logic [1:0]        op_q;
    logic [DATA_W-1:0] a_reg;

    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] rd_data;

    // Fixed-width 1-bit shifter applied to the B operand
    function automatic logic [DATA_W-1:0] shift_b(input logic [DATA_W-1:0] v, input logic [1:0] s);
        logic [DATA_W-1:0] r;
        case (s)
            2'b01:   r = {v[DATA_W-2:0], 1'b0};
            2'b10:   r = {1'b0, v[DATA_W-1:1]};
            2'b11:   r = {v[DATA_W-1], v[DATA_W-1:1]};
            default: r = v;
        endcase
        return r;
    endfunction

    // Single read port: A index in RD_A, B index otherwise
    always_comb begin
        rd_idx = (state == RD_A) ? rn_q : rm_q;
`ifdef OPF_BYPASS_EN
        rd_data = (bus.wb_en && (bus.wb_num == rd_idx)) ? bus.wb_data : regs[rd_idx];
`else
        rd_data = regs[rd_idx];
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath enables
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        load_a     = 1'b0;
        load_b     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.issue_valid) begin
                    accept     = 1'b1;
                    state_next = RD_A;
                end
            end
            RD_A: begin
                load_a     = 1'b1;
                state_next = RD_B;
            end
            RD_B: begin
                load_b     = 1'b1;
                state_next = OUT;
            end
            OUT: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered handshake outputs, latched controls and operand outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.issue_ready <= 1'b1;
            bus.out_valid   <= 1'b0;
            bus.ain         <= '0;
            bus.bin         <= '0;
            bus.aluop       <= '0;
            rn_q            <= '0;
            rm_q            <= '0;
            shift_q         <= '0;
            asel_q          <= 1'b0;
            bsel_q          <= 1'b0;
            imm_q           <= '0;
            op_q            <= '0;
            a_reg           <= '0;
        end else begin
            bus.issue_ready <= (state_next == IDLE);
            bus.out_valid   <= (state_next == OUT);
            if (accept) begin
                rn_q    <= bus.rn;
                rm_q    <= bus.rm;
                shift_q <= bus.shift;
                asel_q  <= bus.asel;
                bsel_q  <= bus.bsel;
                imm_q   <= bus.sximm5;
                op_q    <= bus.aluop_in;
            end
            if (load_a) begin
                a_reg <= rd_data;
            end
            // ain/bin/aluop are loaded once on entry to OUT and then held
            if (load_b) begin
                bus.ain   <= asel_q ? '0 : a_reg;
                bus.bin   <= bsel_q ? imm_q : shift_b(rd_data, shift_q);
                bus.aluop <= op_q;
            end
        end
    end

    // Register file write port, active in every state outside reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs <= '{default: '0};
        end else if (bus.wb_en) begin
            regs[bus.wb_num] <= bus.wb_data;
        end
    end
endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios plus randomized operations with
// random writeback traffic, checked against a register-array reference model.
module tb_operand_fetch;
    logic clk;
    logic rst_n;

    operand_fetch_if #(.DATA_W(16), .IDX_W(3)) bus ();

    operand_fetch dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

`ifdef OPF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic [15:0] mregs [8];
    int n_checks = 0;
    int n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: reference register file follows the write port at the rising edge
    task automatic cyc();
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) mregs[i] = 16'h0000;
        end else if (bus.wb_en) begin
            mregs[bus.wb_num] = bus.wb_data;
        end
        @(negedge clk);
    endtask

    function automatic logic [15:0] ref_shift(input logic [15:0] v, input logic [1:0] s);
        int u;
        u = 32'(v);
        case (s)
            2'b01:   u = (u * 2) % 65536;
            2'b10:   u = u / 2;
            2'b11:   u = u / 2 + ((u >= 32768) ? 32768 : 0);
            default: u = u;
        endcase
        return 16'(u);
    endfunction

    // Value an operand read sees at the coming edge, given the write currently driven
    function automatic logic [15:0] model_read(input logic [2:0] idx);
        if (BYP && bus.wb_en && (bus.wb_num == idx)) return bus.wb_data;
        return mregs[idx];
    endfunction

    task automatic drive_wb(input bit rnd);
        if (rnd) begin
            bus.wb_en   = ($urandom % 3) == 0;
            bus.wb_num  = 3'($urandom % 8);
            bus.wb_data = 16'($urandom);
        end else begin
            bus.wb_en   = 1'b0;
            bus.wb_num  = 3'd0;
            bus.wb_data = 16'h0000;
        end
    endtask

    task automatic write_reg(input logic [2:0] num, input logic [15:0] data);
        bus.wb_en   = 1'b1;
        bus.wb_num  = num;
        bus.wb_data = data;
        cyc();
        drive_wb(1'b0);
    endtask

    task automatic scramble_issue();
        bus.rn       = 3'($urandom % 8);
        bus.rm       = 3'($urandom % 8);
        bus.shift    = 2'($urandom % 4);
        bus.asel     = 1'($urandom % 2);
        bus.bsel     = 1'($urandom % 2);
        bus.sximm5   = 16'($urandom);
        bus.aluop_in = 2'($urandom % 4);
    endtask

    // Full operation: issue, two read cycles, OUT held for 'hold' cycles, then consumed
    task automatic do_op(input logic [2:0] rn, input logic [2:0] rm, input logic [1:0] sh,
                         input logic asel, input logic bsel, input logic [15:0] imm,
                         input logic [1:0] op, input int hold, input bit rnd,
                         input bit fw_en, input logic [2:0] fw_num, input logic [15:0] fw_data);
        logic [15:0] ea;
        logic [15:0] eb;
        logic [15:0] exp_a;
        logic [15:0] exp_b;

        check("idle_ready", 32'(bus.issue_ready), 32'd1);
        check("idle_valid", 32'(bus.out_valid), 32'd0);
        bus.issue_valid = 1'b1;
        bus.rn = rn; bus.rm = rm; bus.shift = sh; bus.asel = asel; bus.bsel = bsel;
        bus.sximm5 = imm; bus.aluop_in = op;
        bus.out_ready = 1'b0;
        drive_wb(rnd);
        cyc();

        // RD_A edge: issue inputs changed behind the latch must not matter
        bus.issue_valid = rnd ? 1'($urandom % 2) : 1'b0;
        if (rnd) scramble_issue();
        bus.out_ready = rnd ? 1'($urandom % 2) : 1'b0;
        if (fw_en) begin
            bus.wb_en = 1'b1; bus.wb_num = fw_num; bus.wb_data = fw_data;
        end else begin
            drive_wb(rnd);
        end
        ea = model_read(rn);
        cyc();
        check("rda_ready", 32'(bus.issue_ready), 32'd0);
        check("rda_valid", 32'(bus.out_valid), 32'd0);

        // RD_B edge
        drive_wb(rnd);
        eb = model_read(rm);
        cyc();
        exp_a = asel ? 16'h0000 : ea;
        exp_b = bsel ? imm : ref_shift(eb, sh);
        check("out_valid", 32'(bus.out_valid), 32'd1);
        check("out_ready_lo", 32'(bus.issue_ready), 32'd0);
        check("ain", 32'(bus.ain), 32'(exp_a));
        check("bin", 32'(bus.bin), 32'(exp_b));
        check("aluop", 32'(bus.aluop), 32'(op));

        for (int h = 0; h < hold; h++) begin
            bus.out_ready   = 1'b0;
            bus.issue_valid = 1'b1;
            scramble_issue();
            drive_wb(rnd);
            cyc();
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_ready", 32'(bus.issue_ready), 32'd0);
            check("hold_ain", 32'(bus.ain), 32'(exp_a));
            check("hold_bin", 32'(bus.bin), 32'(exp_b));
            check("hold_aluop", 32'(bus.aluop), 32'(op));
        end

        bus.out_ready = 1'b1;
        drive_wb(rnd);
        cyc();
        bus.out_ready   = 1'b0;
        bus.issue_valid = 1'b0;
        drive_wb(1'b0);
        check("done_valid", 32'(bus.out_valid), 32'd0);
        check("done_ready", 32'(bus.issue_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.issue_valid = 1'b0;
        bus.out_ready   = 1'b0;
        scramble_issue();
        drive_wb(1'b0);
        for (int i = 0; i < 8; i++) mregs[i] = 16'hDEAD;
        @(negedge clk);
        bus.wb_en = 1'b1; bus.wb_num = 3'd5; bus.wb_data = 16'h1234;
        cyc();
        cyc();
        rst_n = 1'b1;
        drive_wb(1'b0);

        // Reset state, then every register reads as zero
        check("rst_ready", 32'(bus.issue_ready), 32'd1);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_ain", 32'(bus.ain), 32'd0);
        check("rst_bin", 32'(bus.bin), 32'd0);
        check("rst_aluop", 32'(bus.aluop), 32'd0);
        for (int k = 0; k < 4; k++)
            do_op(3'(2 * k), 3'(2 * k + 1), 2'b00, 1'b0, 1'b0, 16'h0000, 2'b10, 0, 1'b0, 1'b0, 3'd0, 16'h0);

        // Basic add operands
        write_reg(3'd1, 16'h0005);
        write_reg(3'd2, 16'h0003);
        do_op(3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b01, 0, 1'b0, 1'b0, 3'd0, 16'h0);

        // Shifter variants on a shared register
        write_reg(3'd3, 16'h8001);
        for (int s = 1; s < 4; s++)
            do_op(3'd3, 3'd3, 2'(s), 1'b0, 1'b0, 16'h0000, 2'b00, 0, 1'b0, 1'b0, 3'd0, 16'h0);

        // Source selects with back-pressure
        do_op(3'd1, 3'd2, 2'b01, 1'b1, 1'b1, 16'hFFF0, 2'b11, 5, 1'b0, 1'b0, 3'd0, 16'h0);

        // Write to the register being read on the RD_A edge
        write_reg(3'd4, 16'h0001);
        do_op(3'd4, 3'd4, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b00, 0, 1'b0, 1'b1, 3'd4, 16'h00AA);
        write_reg(3'd6, 16'h0000);
        do_op(3'd4, 3'd6, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b00, 0, 1'b0, 1'b0, 3'd0, 16'h0);
        check("fwd_r4", 32'(bus.ain), 32'h00AA);

        // Randomized operations with random writeback traffic
        for (int n = 0; n < 60; n++)
            do_op(3'($urandom % 8), 3'($urandom % 8), 2'($urandom % 4), 1'($urandom % 2),
                  1'($urandom % 2), 16'($urandom), 2'($urandom % 4), int'($urandom % 4),
                  1'b1, 1'b0, 3'd0, 16'h0);

        // Reset during RD_B aborts the operation
        bus.issue_valid = 1'b1;
        bus.rn = 3'd1; bus.rm = 3'd2; bus.shift = 2'b00; bus.asel = 1'b0; bus.bsel = 1'b0;
        bus.sximm5 = 16'h0000; bus.aluop_in = 2'b01;
        cyc();
        bus.issue_valid = 1'b0;
        cyc();
        rst_n = 1'b0;
        bus.wb_en = 1'b1; bus.wb_num = 3'd2; bus.wb_data = 16'h7777;
        cyc();
        rst_n = 1'b1;
        drive_wb(1'b0);
        check("abort_valid", 32'(bus.out_valid), 32'd0);
        check("abort_ready", 32'(bus.issue_ready), 32'd1);
        check("abort_ain", 32'(bus.ain), 32'd0);
        check("abort_bin", 32'(bus.bin), 32'd0);
        for (int c = 0; c < 3; c++) begin
            cyc();
            check("abort_idle", 32'(bus.out_valid), 32'd0);
        end
        do_op(3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b01, 0, 1'b0, 1'b0, 3'd0, 16'h0);
        check("abort_r2", 32'(bus.bin), 32'd0);
        write_reg(3'd7, 16'hBEEF);
        do_op(3'd7, 3'd7, 2'b10, 1'b0, 1'b0, 16'h0000, 2'b10, 1, 1'b0, 1'b0, 3'd0, 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
